// File: rtl/score_disp_ctrl.sv
// Score/best keeper with a 4-digit multiplexed 7-segment scan driver.
// Outputs are registered one cycle behind the scan state; a frame buffer holds the page shown.
module score_disp_ctrl #(
    parameter int SCAN_DIV  = 10000,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lose,
    input  logic       clr,
    input  logic       show_best,
    output logic [3:0] select,
    output logic [6:0] seg
);

    localparam int MAX_CYC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CW      = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    typedef enum logic {
        ST_SCAN,
        ST_BLANK
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [1:0]    digit_reg;
    logic          lose_d_reg;
    logic [15:0]   score_reg;
    logic [15:0]   best_reg;
    logic [15:0]   buf_reg;
    logic [15:0]   score_next;
    logic [3:0]    carry;
    logic [3:0]    digit_on;
    logic [3:0]    cur_digit;
    logic          lose_event;

    function automatic logic [6:0] decode_seg(input logic [3:0] v);
        case (v)
            4'd0:    decode_seg = 7'h40;
            4'd1:    decode_seg = 7'h79;
            4'd2:    decode_seg = 7'h24;
            4'd3:    decode_seg = 7'h30;
            4'd4:    decode_seg = 7'h19;
            4'd5:    decode_seg = 7'h12;
            4'd6:    decode_seg = 7'h02;
            4'd7:    decode_seg = 7'h78;
            4'd8:    decode_seg = 7'h00;
            4'd9:    decode_seg = 7'h10;
            default: decode_seg = 7'h7F;
        endcase
    endfunction

    assign carry[0] = 1'b1;

    // BCD ripple increment; a digit advances only when every lower digit is 9.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            logic [3:0] d;
            assign d = score_reg[4*gi +: 4];
            assign score_next[4*gi +: 4] = !carry[gi] ? d :
                                           (d == 4'd9) ? 4'd0 : d + 4'd1;
            if (gi < 3) begin : g_carry
                assign carry[gi+1] = carry[gi] && (d == 4'd9);
            end
            assign digit_on[gi] = (gi == 0) || (buf_reg[15:4*gi] != 16'd0);
        end
    endgenerate

    assign lose_event = lose && !lose_d_reg;
    assign cur_digit  = buf_reg[4*digit_reg +: 4];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_SCAN;
            cnt_reg    <= '0;
            digit_reg  <= 2'd0;
            lose_d_reg <= 1'b0;
            score_reg  <= 16'h0000;
            best_reg   <= 16'h0000;
            buf_reg    <= 16'h0000;
            select     <= 4'b1111;
            seg        <= 7'h7F;
        end else begin
            lose_d_reg <= lose;

            // Nibbles never exceed 9, so a plain vector compare is MSD-first BCD order.
            if (clr) begin
                score_reg <= 16'h0000;
                if (score_reg > best_reg)
                    best_reg <= score_reg;
            end else if (lose_event) begin
                score_reg <= score_next;
            end

            if (state_reg == ST_SCAN) begin
                select <= ~(4'b0001 << digit_reg);
                seg    <= digit_on[digit_reg] ? decode_seg(cur_digit) : 7'h7F;
            end else begin
                select <= 4'b1111;
                seg    <= 7'h7F;
            end

            case (state_reg)
                ST_SCAN: begin
                    if (cnt_reg == SCAN_LAST) begin
                        cnt_reg <= '0;
                        if (BLANK_CYC == 0) begin
                            digit_reg <= digit_reg + 2'd1;
                            if (digit_reg == 2'd3)
                                buf_reg <= show_best ? best_reg : score_reg;
                        end else begin
                            state_reg <= ST_BLANK;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (cnt_reg == BLANK_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_SCAN;
                        digit_reg <= digit_reg + 2'd1;
                        if (digit_reg == 2'd3)
                            buf_reg <= show_best ? best_reg : score_reg;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_SCAN;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_disp_ctrl.sv
// Randomized and directed bench for score_disp_ctrl against a decimal/time-slot reference model.
// Every cycle the select/seg outputs are compared with the model's prediction.
module tb_score_disp_ctrl;

    localparam int SD    = 4;
    localparam int BC    = 2;
    localparam int SLOT  = SD + BC;
    localparam int FRAME = 4 * SLOT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lose = 1'b0;
    logic       clr = 1'b0;
    logic       show_best = 1'b0;
    logic [3:0] select;
    logic [6:0] seg;

    int n_checks = 0;
    int n_errors = 0;

    int m_score = 0;
    int m_best  = 0;
    int m_buf   = 0;
    int m_t     = 0;
    bit m_lose_d = 1'b0;
    int n_events = 0;

    int seg_tab [10] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78, 'h00, 'h10};
    int pow10   [4]  = '{1, 10, 100, 1000};

    score_disp_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk       (clk),
        .rst       (rst),
        .lose      (lose),
        .clr       (clr),
        .show_best (show_best),
        .select    (select),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: predict outputs from pre-edge model state, advance model, then compare.
    task automatic cyc(input bit l, input bit c, input bit sb, input bit r);
        int p, slot, w, dv;
        logic [3:0] exp_sel;
        logic [6:0] exp_seg;
        lose = l; clr = c; show_best = sb; rst = r;
        if (r) begin
            exp_sel = 4'hF; exp_seg = 7'h7F;
            m_score = 0; m_best = 0; m_buf = 0; m_t = 0; m_lose_d = 1'b0;
        end else begin
            p = m_t % FRAME;
            slot = p / SLOT;
            w = p % SLOT;
            if (w < SD) begin
                exp_sel = ~(4'(1) << slot);
                dv = (m_buf / pow10[slot]) % 10;
                if (slot > 0 && m_buf < pow10[slot]) exp_seg = 7'h7F;
                else exp_seg = 7'(seg_tab[dv]);
            end else begin
                exp_sel = 4'hF; exp_seg = 7'h7F;
            end
            if (p == FRAME - 1) m_buf = sb ? m_best : m_score;
            if (c) begin
                if (m_score > m_best) m_best = m_score;
                m_score = 0;
            end else if (l && !m_lose_d) begin
                m_score = (m_score + 1) % 10000;
            end
            m_lose_d = l;
            m_t++;
        end
        @(posedge clk);
        #1;
        check_eq("select", 16'(select), 16'(exp_sel));
        check_eq("seg", 16'(seg), 16'(exp_seg));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, show_best, 1'b0);
    endtask

    task automatic events(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, show_best, 1'b0);
            cyc(1'b0, 1'b0, show_best, 1'b0);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        bit l, c, sb;
        // Reset then idle scan pattern
        do_reset(3);
        idle(2 * FRAME);
        $display("txn reset_idle: model score=%0d best=%0d", m_score, m_best);

        // Held-high lose counts once, then three single pulses
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        events(3);
        idle(2 * FRAME);
        check_eq("score_after_hold", 16'(m_buf), 16'd4);
        $display("txn hold_and_pulses: model score=%0d", m_score);

        // Full wrap 9999 -> 0000
        do_reset(1);
        events(9999);
        idle(FRAME);
        events(1);
        idle(2 * FRAME);
        $display("txn wrap: model score=%0d best=%0d", m_score, m_best);

        // best=0050, score=0123, clr, then show_best mid-frame
        do_reset(1);
        events(50);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        events(123);
        idle(FRAME);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        idle(FRAME + 7);
        show_best = 1'b1;
        idle(2 * FRAME);
        check_eq("best_page", 16'(m_buf), 16'd123);
        show_best = 1'b0;
        $display("txn clr_best_page: model score=%0d best=%0d", m_score, m_best);

        // clr and lose edge in the same cycle
        do_reset(1);
        events(7);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        idle(2 * FRAME);
        $display("txn clr_vs_event: model score=%0d best=%0d", m_score, m_best);

        // Reset during SCAN(2)
        do_reset(1);
        events(42);
        while ((m_t % FRAME) != 2 * SLOT + 1) idle(1);
        do_reset(1);
        idle(2 * FRAME);
        $display("txn mid_frame_reset: model score=%0d", m_score);

        // Random traffic
        sb = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            l  = ($urandom_range(0, 2) == 0);
            c  = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 40) == 0) sb = ~sb;
            if ($urandom_range(0, 999) == 0) cyc(l, c, sb, 1'b1);
            else cyc(l, c, sb, 1'b0);
            if (l && !c) n_events++;
        end
        $display("txn random: model score=%0d best=%0d", m_score, m_best);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/score_disp_ctrl.md
SCORE_DISP_CTRL -- requirements
Module: score_disp_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 10000: number of clk cycles each digit is driven.
REQ-002 SHALL have parameter BLANK_CYC, default 16: number of clk cycles all digits are off between digits; 0 means no blank phase.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge of clk.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port lose, input, 1 bit: level from the game; each rising edge of lose is one score event.
REQ-006 SHALL have port clr, input, 1 bit: one-cycle new-game pulse.
REQ-007 SHALL have port show_best, input, 1 bit: page select; 0 selects the score page, 1 selects the best page.
REQ-008 SHALL have port select, output, 4 bits, registered: active-low digit enable; select[0] is the rightmost digit.
REQ-009 SHALL have port seg, output, 7 bits, registered: active-low segments, seg[6:0] = g,f,e,d,c,b,a.

Function
REQ-010 SHALL detect an event as lose=1 while the registered copy of lose from the previous cycle is 0; a held-high lose counts once.
REQ-011 SHALL, on an event, increment a 4-digit BCD score register by 1 on the next edge: digit carry 9->0, and 9999 wraps to 0000.
REQ-012 SHALL, on clr, load score with 0000 and load best with score if score > best, both on the same edge.
REQ-013 SHALL give clr priority when clr and an event occur in the same cycle: the event is dropped, and the best compare uses the pre-clear score.
REQ-014 SHALL compare score and best as 4-digit BCD values, most-significant digit first.
REQ-015 SHALL run a scan FSM with two states:
- SCAN(d) drives digit d for SCAN_DIV cycles.
- SCAN(d) then goes to BLANK; if BLANK_CYC=0 it goes directly to SCAN(d+1 mod 4).
- BLANK drives select=4'b1111 and seg=7'h7F for BLANK_CYC cycles, then goes to SCAN(d+1 mod 4).
REQ-016 SHALL, in SCAN(d), drive select with bit d = 0 and all other bits = 1.
REQ-017 SHALL sample show_best only on entry to SCAN(0), so a page change never mixes pages within one frame.
REQ-018 SHALL sample the displayed page's four digits into a frame buffer on entry to SCAN(0); score changes mid-frame appear in the next frame.
REQ-019 SHALL decode digit values 0-9 as: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 (hex).
REQ-020 SHALL blank a digit with seg=7'h7F when it is a leading zero:
- Digit d (d > 0) is a leading zero when it and all higher buffered digits are 0.
- Digit 0 is never suppressed.
REQ-021 SHALL implement the dwell counter with width ceil(log2(max(SCAN_DIV, BLANK_CYC) + 1)) and SHALL reset it to 0 on every state change.
REQ-022 SHALL present outputs with one cycle of latency from the FSM state: select and seg are registered from the state and digit index.

Reset
REQ-023 SHALL, while rst=1, set score=0000, best=0000, frame buffer=0000, lose_d=0, FSM=SCAN(0), dwell counter=0, select=4'b1111, seg=7'h7F.
REQ-024 SHALL ignore lose, clr and show_best while rst=1.
REQ-025 SHALL, when rst is asserted mid-frame or mid-increment, abandon all state in that cycle with no partial update.
REQ-026 SHALL drive select=4'b1110 and seg=7'h40 on the first edge after rst deasserts.

Verification (SCAN_DIV=4, BLANK_CYC=2)
REQ-027 Reset then idle -> select sequence 1110x4, 1111x2, 1101x4, 1111x2, 1011x4, 1111x2, 0111x4, then repeats; seg=40 on digit 0 and 7F on every other digit.
REQ-028 Hold lose=1 for 10 cycles, then 3 further single pulses -> score=0004; next frame shows digit 0 = 19 and digits 1-3 blank.
REQ-029 Preload score=9999 via 9999 events, then one more event -> score=0000, no overflow side effect.
REQ-030 Score=0123 with best=0050, pulse clr -> best=0123, score=0000; set show_best=1 mid-frame -> page changes only at the next SCAN(0) entry, then shows 1:79 2:24 3:30 with digit 3 blank.
REQ-031 clr and a lose rising edge in the same cycle with score=0007 -> score=0000, best=0007, event lost.
REQ-032 Assert rst during SCAN(2) with score=0042 -> all registers at reset values on the next edge, select=1111; after release the scan restarts at digit 0.
